median3_window_feeder: RTL and testbench

Streaming front-end for the 3-input combinational median sorter (`sorting` module). It accepts one 8-bit sample per handshake and maintains a sliding 3-sample window with edge handling at frame boundaries. It presents that window as registered operands a/b/c with valid/ready flow control. Each frame of N input samples produces exactly N windows, so the downstream median stream is length-preserving.

---
 rtl/median3_window_feeder.sv | 115 +++++++++++
 tb/tb_median3_window_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/median3_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : median3_window_feeder
// Summary  : Builds sliding 3-sample windows (a=x[i-1], b=x[i], c=x[i+1]) for
//            a median-of-3 sorter and handles the frame edges. Each frame of N
//            samples yields N windows. The output slot is registered and uses
//            valid/ready flow control.
//            MEDIAN3_ZERO_PAD_EN: pad the frame edges with zero instead of
//            replicating the edge sample.
// Revision : 1.0 - initial release
// ============================================================================
module median3_window_feeder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic              out_last
);

`ifdef MEDIAN3_ZERO_PAD_EN
    localparam logic ZERO_PAD = 1'b1;
`else
    localparam logic ZERO_PAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] prev, cur, prev_nxt, cur_nxt;
    logic [DATA_W-1:0] win_a, win_b, win_c;
    logic              win_last, emit, slot_free, accept;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) || ((state == RUN) && slot_free);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        cur_nxt   = cur;
        emit      = 1'b0;
        win_a     = prev;
        win_b     = cur;
        win_c     = in_data;
        win_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // The first sample of a frame becomes its own left neighbour.
                    prev_nxt  = ZERO_PAD ? '0 : in_data;
                    cur_nxt   = in_data;
                    state_nxt = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    emit      = 1'b1;
                    prev_nxt  = cur;
                    cur_nxt   = in_data;
                    state_nxt = in_last ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    win_c     = ZERO_PAD ? '0 : cur;
                    win_last  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            cur       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
            cur   <= cur_nxt;
            if (emit) begin
                out_valid <= 1'b1;
                out_a     <= win_a;
                out_b     <= win_b;
                out_c     <= win_c;
                out_last  <= win_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median3_window_feeder.sv
`default_nettype none
// Testbench for median3_window_feeder: directed frames plus randomized traffic.
// Windows are compared against a frame-level reference model.
module tb_median3_window_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_a, out_b, out_c;

    int tests = 0;
    int fails = 0;

    logic [7:0]  cur_frame[$];
    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];

    median3_window_feeder #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] pad_val(input logic [7:0] x);
`ifdef MEDIAN3_ZERO_PAD_EN
        return 8'd0;
`else
        return x;
`endif
    endfunction

    // Reference model: a completed frame of N samples maps to N windows.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                cur_frame.push_back(in_data);
                if (in_last) begin
                    for (int i = 0; i < cur_frame.size(); i++) begin
                        logic [7:0] a, c;
                        a = (i == 0) ? pad_val(cur_frame[0]) : cur_frame[i-1];
                        c = (i == cur_frame.size() - 1) ? pad_val(cur_frame[i]) : cur_frame[i+1];
                        exp_q.push_back({(i == cur_frame.size() - 1), a, cur_frame[i], c});
                    end
                    cur_frame.delete();
                end
            end
            if (out_valid && out_ready)
                obs_q.push_back({out_last, out_a, out_b, out_c});
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain_and_compare(input string tag);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_win"}, {7'd0, obs_q[i]}, {7'd0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit done;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_abc", {out_a, out_b, out_c}, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(8'd10, 0); send(8'd50, 0); send(8'd20, 0); send(8'd40, 1);
        drain_and_compare("frame4");

        send(8'd7, 1);
        drain_and_compare("single");
        @(negedge clk);
        check("single_idle_ready", in_ready, 1);
        @(posedge clk); #1;

        // Stall the consumer for three cycles while window (1,2,3) is presented.
        fork
            begin
                send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0); send(8'd5, 1);
            end
            begin
                bit seen = 0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(posedge clk); #1;
                    if (out_valid && out_a == 8'd1 && out_b == 8'd2 && out_c == 8'd3) seen = 1;
                end
                check("stall_seen", seen, 1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {out_a, out_b, out_c}, {8'd1, 8'd2, 8'd3});
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain_and_compare("stall");

        send(8'd9, 0); send(8'd8, 1); send(8'd3, 1);
        drain_and_compare("b2b");

        send(8'd5, 0); send(8'd6, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        obs_q.delete(); exp_q.delete(); cur_frame.delete();
        send(8'd4, 1);
        drain_and_compare("post_rst");

        send(8'd10, 0); send(8'd50, 1);
        drain_and_compare("two");

        done = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #1;
                        send(8'($urandom), (i == n - 1));
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        drain_and_compare("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
